// File: rtl/issue_ctrl_pkg.sv
// Shared opcode/funct encodings, issue-mode values and predecode record for the issue stage.
package issue_ctrl_pkg;

  localparam int STALL_BUS_W = 6;

  localparam logic SingleIssue = 1'b0;
  localparam logic DualIssue   = 1'b1;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_LUI     = 6'h0f;
  localparam logic [5:0] OP_COP0    = 6'h10;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LWR     = 6'h26;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SH      = 6'h29;
  localparam logic [5:0] OP_SWL     = 6'h2a;
  localparam logic [5:0] OP_SW      = 6'h2b;
  localparam logic [5:0] OP_SWR     = 6'h2e;

  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_JALR    = 6'h09;
  localparam logic [5:0] FN_SYSCALL = 6'h0c;
  localparam logic [5:0] FN_BREAK   = 6'h0d;
  localparam logic [5:0] FN_MFHI    = 6'h10;
  localparam logic [5:0] FN_MTLO    = 6'h13;
  localparam logic [5:0] FN_MULT    = 6'h18;
  localparam logic [5:0] FN_DIVU    = 6'h1b;

  localparam logic [4:0] RT_BLTZAL  = 5'h10;
  localparam logic [4:0] RT_BGEZAL  = 5'h11;
  localparam logic [4:0] REG_RA     = 5'd31;

  typedef enum logic {
    NORMAL  = 1'b0,
    WAIT_DS = 1'b1
  } state_e;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] dest;
    logic       is_load;
    logic       is_store;
    logic       is_br;
    logic       is_special;
  } predecode_t;

endpackage

// File: rtl/issue_predecode.sv
// Combinational predecode of one buffer-head instruction: register fields and class flags.
module issue_predecode
  import issue_ctrl_pkg::*;
(
  input  logic [31:0] inst_i,
  output predecode_t  pd_o
);

  logic [5:0] op;
  logic [5:0] funct;

  assign op    = inst_i[31:26];
  assign funct = inst_i[5:0];

  always_comb begin
    pd_o    = '0;
    pd_o.rs = inst_i[25:21];
    pd_o.rt = inst_i[20:16];
    if (op == OP_SPECIAL) begin
      pd_o.dest       = inst_i[15:11];
      pd_o.is_br      = (funct == FN_JR) || (funct == FN_JALR);
      pd_o.is_special = (funct == FN_SYSCALL) || (funct == FN_BREAK) ||
                        (funct >= FN_MFHI && funct <= FN_MTLO) ||
                        (funct >= FN_MULT && funct <= FN_DIVU);
    end else if (op == OP_REGIMM) begin
      pd_o.is_br = 1'b1;
      if (inst_i[20:16] == RT_BLTZAL || inst_i[20:16] == RT_BGEZAL)
        pd_o.dest = REG_RA;
    end else if (op == OP_J || (op >= OP_BEQ && op <= OP_BGTZ)) begin
      pd_o.is_br = 1'b1;
    end else if (op == OP_JAL) begin
      pd_o.is_br = 1'b1;
      pd_o.dest  = REG_RA;
    end else if (op >= OP_ADDI && op <= OP_LUI) begin
      pd_o.dest = inst_i[20:16];
    end else if (op == OP_COP0) begin
      // MFC0/MTC0/ERET all serialise against CP0 state
      pd_o.is_special = 1'b1;
    end else if (op >= OP_LB && op <= OP_LWR) begin
      pd_o.is_load = 1'b1;
      pd_o.dest    = inst_i[20:16];
    end else if (op == OP_SB || op == OP_SH || op == OP_SWL ||
                 op == OP_SW || op == OP_SWR) begin
      pd_o.is_store = 1'b1;
    end
  end

endmodule

// File: rtl/issue_ctrl.sv
// Dual-issue decision for the two buffer-head instructions and the slot-0/slot-1 ID registers.
module issue_ctrl
  import issue_ctrl_pkg::*;
#(
  parameter int STALL_W   = STALL_BUS_W,
  parameter int ISSUE_IDX = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic [STALL_W-1:0] stall,
  input  logic [31:0]        inst1_i,
  input  logic [31:0]        inst2_i,
  input  logic [31:0]        inst1_addr_i,
  input  logic [31:0]        inst2_addr_i,
  input  logic               inst1_valid_i,
  input  logic               inst2_valid_i,
  output logic               issue_o,
  output logic               issue_mode_o,
  output logic [31:0]        id_inst1_o,
  output logic [31:0]        id_inst2_o,
  output logic [31:0]        id_pc1_o,
  output logic [31:0]        id_pc2_o,
  output logic               id_valid1_o,
  output logic               id_valid2_o
);

  predecode_t pd1, pd2;
  state_e     state_q;
  logic [4:0] ld_dest_q;
  logic [31:0] id_inst1_q, id_inst2_q, id_pc1_q, id_pc2_q;
  logic        id_valid1_q, id_valid2_q;
  logic        stall_issue, stall_dec, raw12, both_mem, can_dual;
  logic        ld_hit1, ld_hit2, interlock;
  logic        stall_unused;

  issue_predecode u_pd1 (.inst_i(inst1_i), .pd_o(pd1));
  issue_predecode u_pd2 (.inst_i(inst2_i), .pd_o(pd2));

  assign stall_issue  = stall[ISSUE_IDX];
  assign stall_dec    = stall[ISSUE_IDX+1];
  assign stall_unused = ^stall;

  assign raw12    = (pd1.dest != 5'd0) && (pd2.rs == pd1.dest || pd2.rt == pd1.dest);
  assign both_mem = (pd1.is_load | pd1.is_store) & (pd2.is_load | pd2.is_store);
  assign can_dual = inst1_valid_i & inst2_valid_i & ~raw12 & ~both_mem & ~pd2.is_br &
                    ~pd1.is_special & ~pd2.is_special & (state_q == NORMAL);

  // Load result is not forwardable in the cycle right after the load issues
  assign ld_hit1   = (ld_dest_q != 5'd0) && (pd1.rs == ld_dest_q || pd1.rt == ld_dest_q);
  assign ld_hit2   = (ld_dest_q != 5'd0) && (pd2.rs == ld_dest_q || pd2.rt == ld_dest_q);
  assign interlock = ld_hit1 | (can_dual & ld_hit2);

  assign issue_o      = inst1_valid_i & ~stall_issue & ~flush & ~interlock;
  assign issue_mode_o = (can_dual & issue_o) ? DualIssue : SingleIssue;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      id_inst1_q  <= '0;
      id_inst2_q  <= '0;
      id_pc1_q    <= '0;
      id_pc2_q    <= '0;
      id_valid1_q <= 1'b0;
      id_valid2_q <= 1'b0;
      ld_dest_q   <= '0;
      state_q     <= NORMAL;
    end else if (stall_issue && stall_dec) begin
      // decode is frozen too: keep everything in place
    end else if (!issue_o) begin
      id_inst1_q  <= '0;
      id_inst2_q  <= '0;
      id_pc1_q    <= '0;
      id_pc2_q    <= '0;
      id_valid1_q <= 1'b0;
      id_valid2_q <= 1'b0;
      ld_dest_q   <= '0;
    end else begin
      id_inst1_q  <= inst1_i;
      id_pc1_q    <= inst1_addr_i;
      id_valid1_q <= 1'b1;
      id_inst2_q  <= (issue_mode_o == DualIssue) ? inst2_i : '0;
      id_pc2_q    <= (issue_mode_o == DualIssue) ? inst2_addr_i : '0;
      id_valid2_q <= (issue_mode_o == DualIssue);
      if (pd1.is_load)
        ld_dest_q <= pd1.dest;
      else if (issue_mode_o == DualIssue && pd2.is_load)
        ld_dest_q <= pd2.dest;
      else
        ld_dest_q <= '0;
      case (state_q)
        NORMAL:  if (pd1.is_br && !inst2_valid_i) state_q <= WAIT_DS;
        WAIT_DS: state_q <= NORMAL;
        default: state_q <= NORMAL;
      endcase
    end
  end

  assign id_inst1_o  = id_inst1_q;
  assign id_inst2_o  = id_inst2_q;
  assign id_pc1_o    = id_pc1_q;
  assign id_pc2_o    = id_pc2_q;
  assign id_valid1_o = id_valid1_q;
  assign id_valid2_o = id_valid2_q;

endmodule

// File: tb/tb_issue_ctrl.sv
// Directed bench for issue_ctrl: pairing, RAW, load-use, delay slot, stall and flush cases.
module tb_issue_ctrl;

  logic        clk, rst, flush;
  logic [5:0]  stall;
  logic [31:0] inst1, inst2, addr1, addr2;
  logic        v1, v2;
  logic        issue, mode;
  logic [31:0] id_inst1, id_inst2, id_pc1, id_pc2;
  logic        id_v1, id_v2;

  int n_checks = 0;
  int n_fail   = 0;

  issue_ctrl dut (
    .clk(clk), .rst(rst), .flush(flush), .stall(stall),
    .inst1_i(inst1), .inst2_i(inst2), .inst1_addr_i(addr1), .inst2_addr_i(addr2),
    .inst1_valid_i(v1), .inst2_valid_i(v2),
    .issue_o(issue), .issue_mode_o(mode),
    .id_inst1_o(id_inst1), .id_inst2_o(id_inst2), .id_pc1_o(id_pc1), .id_pc2_o(id_pc2),
    .id_valid1_o(id_v1), .id_valid2_o(id_v2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-assembled MIPS words
  localparam logic [31:0] ADDU_3_1_2 = 32'h00221821; // addu r3,r1,r2
  localparam logic [31:0] ADDU_5_4_6 = 32'h00862821; // addu r5,r4,r6
  localparam logic [31:0] ADDU_7_8_9 = 32'h01093821; // addu r7,r8,r9
  localparam logic [31:0] SUBU_4_3_1 = 32'h00612023; // subu r4,r3,r1
  localparam logic [31:0] LW_2_0_1   = 32'h8c220000; // lw r2,0(r1)
  localparam logic [31:0] ADDU_4_2_3 = 32'h00432021; // addu r4,r2,r3
  localparam logic [31:0] BEQ_1_2    = 32'h10220004; // beq r1,r2,+4
  localparam logic [31:0] MULT_1_2   = 32'h00220018; // mult r1,r2
  localparam logic [31:0] SW_5_0_6   = 32'hacc50000; // sw r5,0(r6)
  localparam logic [31:0] LW_7_0_8   = 32'h8d070000; // lw r7,0(r8)

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic drive(input logic [31:0] i1, input logic [31:0] a1, input logic vv1,
                       input logic [31:0] i2, input logic [31:0] a2, input logic vv2);
    inst1 = i1; addr1 = a1; v1 = vv1;
    inst2 = i2; addr2 = a2; v2 = vv2;
  endtask

  // Inputs change at posedge+1; combinational outputs are sampled mid-cycle
  task automatic mid;
    #4;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; stall = '0;
    drive(32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    tick(); tick();
    rst = 1'b0;
    mid();
    check_eq("rst_valid1", {31'b0, id_v1}, 32'd0);
    check_eq("rst_valid2", {31'b0, id_v2}, 32'd0);
    check_eq("rst_inst1", id_inst1, 32'h0);
    check_eq("rst_issue_idle", {31'b0, issue}, 32'd0);
    tick();

    // Independent pair dual-issues
    drive(ADDU_3_1_2, 32'hBFC00000, 1'b1, ADDU_5_4_6, 32'hBFC00004, 1'b1);
    mid();
    check_eq("dual_issue", {31'b0, issue}, 32'd1);
    check_eq("dual_mode", {31'b0, mode}, 32'd1);
    tick();
    check_eq("dual_v1", {31'b0, id_v1}, 32'd1);
    check_eq("dual_v2", {31'b0, id_v2}, 32'd1);
    check_eq("dual_pc1", id_pc1, 32'hBFC00000);
    check_eq("dual_pc2", id_pc2, 32'hBFC00004);
    check_eq("dual_inst2", id_inst2, ADDU_5_4_6);

    // RAW pair splits
    drive(ADDU_3_1_2, 32'hBFC00008, 1'b1, SUBU_4_3_1, 32'hBFC0000C, 1'b1);
    mid();
    check_eq("raw_mode", {31'b0, mode}, 32'd0);
    check_eq("raw_issue", {31'b0, issue}, 32'd1);
    tick();
    check_eq("raw_v2", {31'b0, id_v2}, 32'd0);
    check_eq("raw_inst2_bubble", id_inst2, 32'h0);
    check_eq("raw_inst1", id_inst1, ADDU_3_1_2);
    drive(SUBU_4_3_1, 32'hBFC0000C, 1'b1, 32'h0, 32'h0, 1'b0);
    tick();
    check_eq("raw_follow_inst1", id_inst1, SUBU_4_3_1);
    check_eq("raw_follow_pc1", id_pc1, 32'hBFC0000C);

    // Load-use interlock: LW, bubble, ADDU
    drive(LW_2_0_1, 32'hBFC00010, 1'b1, ADDU_4_2_3, 32'hBFC00014, 1'b1);
    mid();
    check_eq("lw_mode", {31'b0, mode}, 32'd0);
    tick();
    check_eq("lw_inst1", id_inst1, LW_2_0_1);
    drive(ADDU_4_2_3, 32'hBFC00014, 1'b1, 32'h0, 32'h0, 1'b0);
    mid();
    check_eq("ldu_issue_blocked", {31'b0, issue}, 32'd0);
    tick();
    check_eq("ldu_bubble_inst1", id_inst1, 32'h0);
    check_eq("ldu_bubble_v1", {31'b0, id_v1}, 32'd0);
    mid();
    check_eq("ldu_issue_after", {31'b0, issue}, 32'd1);
    tick();
    check_eq("ldu_inst1", id_inst1, ADDU_4_2_3);

    // Branch alone -> WAIT_DS; delay slot forced single, then back to dual
    drive(BEQ_1_2, 32'hBFC00018, 1'b1, 32'h0, 32'h0, 1'b0);
    mid();
    check_eq("br_issue", {31'b0, issue}, 32'd1);
    check_eq("br_mode", {31'b0, mode}, 32'd0);
    tick();
    check_eq("br_inst1", id_inst1, BEQ_1_2);
    drive(ADDU_5_4_6, 32'hBFC0001C, 1'b1, ADDU_7_8_9, 32'hBFC00020, 1'b1);
    mid();
    check_eq("ds_issue", {31'b0, issue}, 32'd1);
    check_eq("ds_mode_forced", {31'b0, mode}, 32'd0);
    tick();
    check_eq("ds_v2", {31'b0, id_v2}, 32'd0);
    drive(ADDU_7_8_9, 32'hBFC00020, 1'b1, ADDU_5_4_6, 32'hBFC00024, 1'b1);
    mid();
    check_eq("post_ds_mode", {31'b0, mode}, 32'd1);
    tick();

    // Class rules: special and two memory ops never pair
    drive(MULT_1_2, 32'hBFC00028, 1'b1, ADDU_7_8_9, 32'hBFC0002C, 1'b1);
    mid();
    check_eq("special_mode", {31'b0, mode}, 32'd0);
    tick();
    drive(SW_5_0_6, 32'hBFC00030, 1'b1, LW_7_0_8, 32'hBFC00034, 1'b1);
    mid();
    check_eq("mem_mem_mode", {31'b0, mode}, 32'd0);
    tick();

    // Issue stalled, decode running: bubble
    drive(ADDU_3_1_2, 32'hBFC00040, 1'b1, ADDU_5_4_6, 32'hBFC00044, 1'b1);
    stall = 6'b000100;
    mid();
    check_eq("stall_bubble_issue", {31'b0, issue}, 32'd0);
    tick();
    check_eq("stall_bubble_v1", {31'b0, id_v1}, 32'd0);
    check_eq("stall_bubble_inst1", id_inst1, 32'h0);
    stall = 6'b000000;
    tick();
    check_eq("stall_load_pc2", id_pc2, 32'hBFC00044);
    // Issue and decode stalled: hold
    drive(ADDU_7_8_9, 32'hBFC00048, 1'b1, 32'h0, 32'h0, 1'b0);
    stall = 6'b001100;
    mid();
    check_eq("stall_hold_issue", {31'b0, issue}, 32'd0);
    tick();
    check_eq("stall_hold_pc1", id_pc1, 32'hBFC00040);
    check_eq("stall_hold_v2", {31'b0, id_v2}, 32'd1);
    stall = 6'b000000;

    // WAIT_DS survives an empty buffer
    drive(BEQ_1_2, 32'hBFC00050, 1'b1, 32'h0, 32'h0, 1'b0);
    tick();
    drive(32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    mid();
    check_eq("ds_empty_issue", {31'b0, issue}, 32'd0);
    tick();
    drive(ADDU_5_4_6, 32'hBFC00054, 1'b1, ADDU_7_8_9, 32'hBFC00058, 1'b1);
    mid();
    check_eq("ds_after_empty_mode", {31'b0, mode}, 32'd0);
    tick();

    // Flush in WAIT_DS
    drive(BEQ_1_2, 32'hBFC00060, 1'b1, 32'h0, 32'h0, 1'b0);
    tick();
    drive(ADDU_5_4_6, 32'hBFC00064, 1'b1, ADDU_7_8_9, 32'hBFC00068, 1'b1);
    flush = 1'b1;
    mid();
    check_eq("flush_issue", {31'b0, issue}, 32'd0);
    tick();
    flush = 1'b0;
    check_eq("flush_v1", {31'b0, id_v1}, 32'd0);
    check_eq("flush_v2", {31'b0, id_v2}, 32'd0);
    mid();
    check_eq("flush_state_normal", {31'b0, mode}, 32'd1);
    tick();

    // Reset in WAIT_DS
    drive(BEQ_1_2, 32'hBFC00070, 1'b1, 32'h0, 32'h0, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(ADDU_5_4_6, 32'hBFC00074, 1'b1, ADDU_7_8_9, 32'hBFC00078, 1'b1);
    mid();
    check_eq("rst_ds_state_normal", {31'b0, mode}, 32'd1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/issue_ctrl.md
Name: issue_ctrl

Overview:
- Issue stage directly downstream of the instruction FIFO buffer: inspects the two instructions at the buffer head and decides no-issue, single-issue or dual-issue each cycle.
- Drives issue_o/issue_mode_o back to the buffer so it pops 0, 1 or 2 entries on the same clock edge.
- Registers the issued instruction(s) into the slot-0/slot-1 ID pipeline registers.
- Applies MIPS pairing rules, load-use interlock and branch/delay-slot pairing.

Parameters:
- STALL_W, 6, width of the pipeline stall bus.
- ISSUE_IDX, 2, stall-bus bit index owned by the issue stage; stall[ISSUE_IDX+1] is the decode stage.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  pipeline flush (exception/mispredict)
- stall  in  STALL_W  pipeline stall bus
- inst1_i, inst2_i  in  32  buffer head / head+1 instruction
- inst1_addr_i, inst2_addr_i  in  32  matching PCs
- inst1_valid_i, inst2_valid_i  in  1  buffer entry valid
- issue_o  out  1  instructions issued this cycle (combinational)
- issue_mode_o  out  1  0 = single (pop 1), 1 = dual (pop 2); combinational
- id_inst1_o, id_inst2_o  out  32  registered slot-0/slot-1 instruction
- id_pc1_o, id_pc2_o  out  32  registered PCs
- id_valid1_o, id_valid2_o  out  1  registered slot valid

Behaviour:
- Predecode, purely combinational per slot:
  - Fields: rs, rt, write-dest (rd for R-type, rt for I-type ALU/load, 31 for JAL/BGEZAL/BLTZAL, 0 otherwise).
  - Class flags: is_load, is_store, is_br (branch/jump), is_special (MULT/DIV/MF/MT HI-LO, MTC0/MFC0, SYSCALL, BREAK, ERET).
- can_dual is true only when all of the following hold:
  - both inputs are valid;
  - inst2 does not read inst1's nonzero dest;
  - both are not memory operations;
  - inst2 is not is_br;
  - neither instruction is is_special;
  - state is NORMAL.
- When inst1 is is_br, the pair is the branch plus its delay slot and is dual-issued if can_dual holds.
- Load-use interlock:
  - Registered ld_dest holds the dest of a load issued in the previous cycle, in either slot.
  - If ld_dest != 0 and inst1 reads ld_dest, or a dual pair's inst2 reads it: issue_o = 0 for one cycle.
  - ld_dest clears on any cycle with no load issued.
- FSM, 2 states:
  - NORMAL: a branch in slot 1 with inst2_valid_i = 0 issues single and moves to WAIT_DS.
  - WAIT_DS: the next issue is forced single (the delay slot), then returns to NORMAL. issue_o stays 0 while inst1_valid_i = 0.
- issue_o rule: issue_o = inst1_valid_i & ~stall[ISSUE_IDX] & ~flush & ~interlock. issue_mode_o = can_dual & issue_o.
- ID register update on posedge:
  - rst or flush: all id_* outputs = 0, state = NORMAL, ld_dest = 0.
  - stall[ISSUE_IDX] & stall[ISSUE_IDX+1]: hold all registers.
  - stall[ISSUE_IDX] & ~stall[ISSUE_IDX+1]: insert a bubble (id_valid1/2 = 0, id_inst/pc = 0).
  - issue_o: slot 0 takes inst1. Slot 1 takes inst2 if dual, else a zero bubble.
  - No issue: bubble.
- Latency: 1 cycle from buffer head to id_* outputs.
- Flush and issue in the same cycle: flush wins; issue_o = 0, so the buffer does not pop.
- Reset in WAIT_DS: returns to NORMAL.

Decomposition:
- Shared defines: opcode/funct constants, SingleIssue/DualIssue values, StallBus width.
- Natural sub-module: issue_predecode (one instance per slot), which outputs the fields and class flags.

Test Plan:
- ADDU r3,r1,r2 + ADDU r5,r4,r6, both valid -> issue_o = 1, mode = 1. Next cycle id_valid1 = id_valid2 = 1, id_pc1 = 0xBFC00000, id_pc2 = 0xBFC00004.
- ADDU r3,r1,r2 + SUBU r4,r3,r1 (RAW) -> mode = 0. id_valid2 = 0; the following cycle SUBU enters slot 0.
- LW r2,0(r1) then ADDU r4,r2,r3 at head -> one cycle with issue_o = 0, then ADDU issued. id_inst1 sequence: LW, 0, ADDU.
- BEQ at head with inst2_valid = 0 -> single issue, state WAIT_DS. The delay slot arrives with a valid follower -> mode = 0 forced, then NORMAL.
- stall[2] = 1, stall[3] = 0 for one cycle -> issue_o = 0 and the id outputs become a bubble. stall[2] = stall[3] = 1 -> id outputs hold their values.
- flush asserted while in WAIT_DS with valid inputs -> issue_o = 0 that cycle. Next cycle all id_valid = 0, state NORMAL.
